// File: rtl/viterbi_link_ctrl.sv
// Test-link sequencer: PRBS frame into the encoder, burst-error channel
// register, and delayed payload alignment against the decoder output.
//
// Ports
//   clk, rst          : clock, async active-low reset
//   start_i           : run request (ignored while busy_o)
//   frame_len_i       : payload bits per frame
//   err_period_i      : injection period minus one, in channel symbols
//   err_burst_i       : corrupted symbols per period (0 = off)
//   err_mask_i        : XOR mask applied to corrupted symbols
//   enc_bit_o/enc_en_o: encoder bit and enable
//   enc_sym_i/enc_valid_i : encoder symbol stream
//   chan_sym_o/dec_en_o   : registered channel symbol to decoder
//   dec_bit_i         : decoded bit
//   busy_o, done_o    : frame in progress, end-of-frame pulse
//   bit_err_cnt_o     : payload bits decoded wrongly
//   inj_cnt_o         : channel symbols corrupted
module viterbi_link_ctrl #(
  parameter int DEC_LATENCY = 24,
  parameter int TAIL_LEN    = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] frame_len_i,
  input  logic [3:0]       err_period_i,
  input  logic [3:0]       err_burst_i,
  input  logic [1:0]       err_mask_i,
  output logic             enc_bit_o,
  output logic             enc_en_o,
  input  logic [1:0]       enc_sym_i,
  input  logic             enc_valid_i,
  output logic [1:0]       chan_sym_o,
  output logic             dec_en_o,
  input  logic             dec_bit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_err_cnt_o,
  output logic [CNT_W-1:0] inj_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_LAST =
    CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'(DEC_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [CNT_W-1:0] len_q;
  logic [3:0]       per_q;
  logic [3:0]       burst_q;
  logic [1:0]       mask_q;
  logic [3:0]       phase_q;
  logic [6:0]       lfsr_q;
  logic             accept;
  logic             inject;
  logic             tag_in;

  logic [DEC_LATENCY-1:0] dl_tag;
  logic [DEC_LATENCY-1:0] dl_bit;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q + 1'b1;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start_i) begin
          accept   = 1'b1;
          state_nx = (frame_len_i == '0) ?
                     S_FLUSH : S_SEND;
        end
      end
      S_SEND: begin
        if (cnt_q == len_q - 1'b1) begin
          state_nx = S_FLUSH;
          cnt_nx   = '0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign enc_en_o  = (state == S_SEND) ||
                     (state == S_FLUSH);
  assign enc_bit_o = (state == S_SEND) & lfsr_q[6];
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);

  // Only payload bits are tagged; tail and idle
  // entries travel through untagged.
  assign tag_in = enc_en_o & (state == S_SEND);

  assign inject = enc_valid_i & busy_o &
                  (burst_q != 4'd0) &
                  (phase_q < burst_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      per_q   <= '0;
      burst_q <= '0;
      mask_q  <= '0;
      lfsr_q  <= 7'h7F;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      if (accept) begin
        len_q   <= frame_len_i;
        per_q   <= err_period_i;
        burst_q <= err_burst_i;
        mask_q  <= err_mask_i;
        lfsr_q  <= 7'h7F;
      end else if (state == S_SEND) begin
        lfsr_q <= {lfsr_q[5:0],
                   lfsr_q[6] ^ lfsr_q[5]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= '0;
      chan_sym_o <= '0;
      dec_en_o   <= 1'b0;
      inj_cnt_o  <= '0;
    end else begin
      dec_en_o   <= enc_valid_i;
      chan_sym_o <= enc_sym_i ^
                    (inject ? mask_q : 2'b00);
      if (accept) begin
        phase_q <= '0;
      end else if (enc_valid_i) begin
        phase_q <= (phase_q == per_q) ?
                   4'd0 : phase_q + 4'd1;
      end
      if (accept) begin
        inj_cnt_o <= '0;
      end else if (inject && inj_cnt_o != CNT_MAX) begin
        inj_cnt_o <= inj_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_tag        <= '0;
      dl_bit        <= '0;
      bit_err_cnt_o <= '0;
    end else begin
      dl_tag <= {dl_tag[DEC_LATENCY-2:0], tag_in};
      dl_bit <= {dl_bit[DEC_LATENCY-2:0], enc_bit_o};
      if (accept) begin
        bit_err_cnt_o <= '0;
      end else if (dl_tag[DEC_LATENCY-1] &&
                   (dec_bit_i != dl_bit[DEC_LATENCY-1]) &&
                   (bit_err_cnt_o != CNT_MAX)) begin
        bit_err_cnt_o <= bit_err_cnt_o + 1'b1;
      end
    end
  end

endmodule
